// File: rtl/ifu_pkg.sv
// ifu_pkg -- shared constants and types for the instruction fetch unit.
//   NOP_INST    : instruction presented on if_inst whenever if_valid is low
//   PC_STEP     : byte distance between consecutive sequential fetches
//   ifu_state_e : derived fetch state (EMPTY / LIVE / HELD), used for output
//                 selection and debug visibility
package ifu_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          PC_STEP  = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no instruction in the fetch stage (reset or redirect bubble)
        LIVE  = 2'd1,   // instruction word comes straight from IMEM read data
        HELD  = 2'd2    // decode stalled; instruction word parked in the skid register
    } ifu_state_e;

endpackage

// File: rtl/ifu_skid_reg.sv
// ifu_skid_reg -- single-entry data register with a full flag.
//   clk   in  : clock
//   rst   in  : asynchronous active-high reset (empties the entry)
//   load  in  : capture din and mark full
//   clear in  : mark empty; wins over load
//   din   in  : data to capture
//   dout  out : stored data (meaningful only while full)
//   full  out : entry holds data
module ifu_skid_reg #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic             full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- fetch-side master of a 1-cycle-latency synchronous IMEM.
// Owns the PC, drives byte addresses to IMEM, pairs each returned word with
// its PC, absorbs decode stalls with a one-entry skid register (no bubbles on
// release) and takes branch/jump redirects with exactly one bubble.
//
// Ports:
//   clk             in  : clock, all state on rising edge
//   rst             in  : asynchronous active-high reset
//   imem_addr       out : byte address to IMEM; data returns on the next cycle
//   imem_inst       in  : IMEM data for the address presented on the previous edge
//   if_stall        in  : decode cannot accept; if_* outputs hold
//   redirect_valid  in  : taken branch/jump; overrides if_stall
//   redirect_pc     in  : redirect target, low two bits ignored
//   if_valid        out : if_pc/if_inst carry a real instruction
//   if_pc           out : PC of if_inst
//   if_inst         out : instruction, NOP whenever if_valid is low
//   perf_fetch_cnt  out : (IFU_PERF_EN only) instructions accepted by decode
//   perf_bubble_cnt out : (IFU_PERF_EN only) cycles with no valid instruction
//
// Build option: define IFU_PERF_EN to add the two performance counters.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                    bits       = 32,
    parameter int                    addr_width = 12,
    parameter logic [addr_width-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [addr_width-1:0] imem_addr,
    input  logic [bits-1:0]       imem_inst,
    input  logic                  if_stall,
    input  logic                  redirect_valid,
    input  logic [addr_width-1:0] redirect_pc,
    output logic                  if_valid,
    output logic [addr_width-1:0] if_pc,
    output logic [bits-1:0]       if_inst
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_bubble_cnt
`endif
);

    logic [addr_width-1:0] pc_q, pc_next;
    logic [addr_width-1:0] req_pc_q, req_pc_next;
    logic                  req_valid_q, req_valid_next;
    logic                  skid_load, skid_clear;
    logic                  skid_full_q;
    logic [bits-1:0]       skid_q;
    ifu_state_e            state;

    ifu_skid_reg #(
        .width (bits)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (imem_inst),
        .dout  (skid_q),
        .full  (skid_full_q)
    );

    // The fetch state is fully implied by the request and skid flags.
    always_comb begin
        if (skid_full_q)
            state = HELD;
        else if (req_valid_q)
            state = LIVE;
        else
            state = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            req_pc_q    <= req_pc_next;
            req_valid_q <= req_valid_next;
        end
    end

    always_comb begin
        pc_next        = pc_q;
        req_pc_next    = req_pc_q;
        req_valid_next = req_valid_q;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (redirect_valid) begin
            // Whatever IMEM returns next belongs to the old path: drop it.
            pc_next        = redirect_pc & ~addr_width'(3);
            req_valid_next = 1'b0;
            skid_clear     = 1'b1;
        end else if (if_stall) begin
            // Only the first stalled edge carries the word for req_pc_q; after
            // that IMEM is already returning the word at pc_q, so keep the skid.
            skid_load = (state == LIVE);
        end else begin
            // pc_q is the address IMEM is reading now, so it becomes the next
            // instruction's PC; the PC wraps naturally at 2**addr_width.
            req_pc_next    = pc_q;
            req_valid_next = 1'b1;
            pc_next        = pc_q + addr_width'(PC_STEP);
            skid_clear     = 1'b1;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = req_valid_q;
    assign if_pc     = req_pc_q;

    always_comb begin
        unique case (state)
            HELD:    if_inst = skid_q;
            LIVE:    if_inst = imem_inst;
            default: if_inst = bits'(NOP_INST);
        endcase
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (if_valid && !if_stall && !redirect_valid)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (!if_valid)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit -- self-checking bench for instr_fetch_unit.
// IMEM is a 1-cycle registered ROM whose word n reads 32'h1000_0000 + n.
// The reference model tracks only the architecturally visible stream: the
// instruction currently offered to decode and the next PC to be offered.
module tb_instr_fetch_unit;

    localparam int          AW  = 12;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_inst;
    logic          if_stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [31:0]   if_inst;
`ifdef IFU_PERF_EN
    logic [31:0]   perf_fetch_cnt;
    logic [31:0]   perf_bubble_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          m_valid;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_next;
    int unsigned   m_fetch;
    int unsigned   m_bubble;

    instr_fetch_unit #(
        .bits       (32),
        .addr_width (AW),
        .RESET_PC   ('0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .if_stall       (if_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        imem_inst <= 32'h1000_0000 + 32'(imem_addr[AW-1:2]);

    wire [AW+32:0] act = {if_valid, if_pc, if_inst};

    function automatic logic [AW+32:0] exp_out();
        return {m_valid, m_pc, m_valid ? 32'h1000_0000 + 32'(m_pc >> 2) : NOP};
    endfunction

    function automatic void model_reset();
        m_valid  = 1'b0;
        m_pc     = '0;
        m_next   = '0;
        m_fetch  = 0;
        m_bubble = 0;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic st, input logic rd, input logic [AW-1:0] tgt);
        if_stall       = st;
        redirect_valid = rd;
        redirect_pc    = tgt;
        @(posedge clk);
        if (!m_valid) m_bubble++;
        if (m_valid && !st && !rd) m_fetch++;
        if (rd) begin
            m_valid = 1'b0;
            m_next  = {tgt[AW-1:2], 2'b00};
        end else if (!st) begin
            m_valid = 1'b1;
            m_pc    = m_next;
            m_next  = m_next + AW'(4);
        end
        #1;
        $display("cyc stall=%0b redir=%0b tgt=%h -> valid=%0b pc=%h inst=%h",
                 st, rd, tgt, if_valid, if_pc, if_inst);
    endtask

    task automatic test_reset();
        rst = 1'b1; if_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (act !== exp_out()) begin
                n_fail++;
                $display("FAIL reset_out cyc%0d: got %h expected %h", i, act, exp_out());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0);
            n_checks++;
            if (act !== exp_out()) begin
                n_fail++;
                $display("FAIL seq_out %0d: got %h expected %h", i, act, exp_out());
            end
        end
`ifdef IFU_PERF_EN
        n_checks++;
        if (perf_fetch_cnt !== m_fetch || perf_bubble_cnt !== m_bubble) begin
            n_fail++;
            $display("FAIL perf_seq: got fetch=%0d bubble=%0d expected fetch=%0d bubble=%0d",
                     perf_fetch_cnt, perf_bubble_cnt, m_fetch, m_bubble);
        end
`endif
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step(i < 3, 1'b0, '0);
            n_checks++;
            if (act !== exp_out() || imem_addr !== m_next) begin
                n_fail++;
                $display("FAIL stall_out %0d: got %h addr %h expected %h addr %h",
                         i, act, imem_addr, exp_out(), m_next);
            end
        end
    endtask

    task automatic test_redirect();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i == 0, AW'(12'h041));
            n_checks++;
            if (act !== exp_out()) begin
                n_fail++;
                $display("FAIL redirect_out %0d: got %h expected %h", i, act, exp_out());
            end
        end
    endtask

    task automatic test_redirect_stall_held();
        logic [AW-1:0] tgt;
        tgt = AW'($urandom_range(0, (1 << AW) - 1));
        for (int i = 0; i < 5; i++) begin
            step(i < 2, i == 1, tgt);
            n_checks++;
            if (act !== exp_out()) begin
                n_fail++;
                $display("FAIL redir_held_out %0d: got %h expected %h", i, act, exp_out());
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i == 0, AW'(12'hFFA));
            n_checks++;
            if (act !== exp_out()) begin
                n_fail++;
                $display("FAIL wrap_out %0d: got %h expected %h", i, act, exp_out());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                 AW'($urandom_range(0, (1 << AW) - 1)));
            n_checks++;
            if (act !== exp_out() || imem_addr !== m_next) begin
                n_fail++;
                $display("FAIL random_out %0d: got %h addr %h expected %h addr %h",
                         i, act, imem_addr, exp_out(), m_next);
            end
        end
`ifdef IFU_PERF_EN
        n_checks++;
        if (perf_fetch_cnt !== m_fetch || perf_bubble_cnt !== m_bubble) begin
            n_fail++;
            $display("FAIL perf_random: got fetch=%0d bubble=%0d expected fetch=%0d bubble=%0d",
                     perf_fetch_cnt, perf_bubble_cnt, m_fetch, m_bubble);
        end
`endif
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        // Mid-cycle, stall still asserted, skid full: reset must act without a clock edge.
        #3 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (act !== exp_out() || imem_addr !== m_next) begin
            n_fail++;
            $display("FAIL async_rst_out: got %h addr %h expected %h addr %h",
                     act, imem_addr, exp_out(), m_next);
        end
        $display("async rst -> valid=%0b pc=%h inst=%h", if_valid, if_pc, if_inst);
        @(posedge clk); #1;
`ifdef IFU_PERF_EN
        n_checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_bubble_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got fetch=%0d bubble=%0d expected 0 0",
                     perf_fetch_cnt, perf_bubble_cnt);
        end
`endif
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0);
            n_checks++;
            if (act !== exp_out()) begin
                n_fail++;
                $display("FAIL post_rst_out %0d: got %h expected %h", i, act, exp_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_stall_held();
        test_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
